// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler.
// Each cycle it picks ready, not-yet-issued RS entries in round-robin order
// and loads them into free functional-unit issue slots. Entries stay marked
// as issued until they retire (done), so no entry is issued twice.
// flush_valid drops every grant and the whole issued mask.
//
// Per-slot FSM
//   state   | meaning
//   S_IDLE  | slot empty, fu_valid[f]=0
//   S_HOLD  | slot presents fu_idx[f] to FU f and waits for fu_ready[f]
module rs_issue_scheduler #(
    parameter int SIZE   = 8,
    parameter int NUM_FU = 2,
    parameter int IDXW   = $clog2(SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_valid,
    input  logic [SIZE-1:0]        ready,
    input  logic [SIZE-1:0]        done,
    output logic [NUM_FU-1:0]      fu_valid,
    output logic [NUM_FU*IDXW-1:0] fu_idx,
    input  logic [NUM_FU-1:0]      fu_ready,
    output logic [SIZE-1:0]        issued_mask,
    output logic [IDXW-1:0]        rr_ptr
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       r_state [NUM_FU];
    logic [IDXW-1:0]  r_idx   [NUM_FU];
    logic [SIZE-1:0]  r_issued;
    logic [IDXW-1:0]  r_rr;

    logic [SIZE-1:0]   w_cand;
    logic [NUM_FU-1:0] w_free;
    logic [NUM_FU-1:0] w_gnt_v;
    logic [IDXW-1:0]   w_gnt_idx [NUM_FU];
    logic [SIZE-1:0]   w_gnt_mask;
    logic [IDXW-1:0]   w_last;
    logic              w_any;
    logic [IDXW-1:0]   w_scan;
    logic              w_placed;

    // Candidate set and free-slot set for this cycle.
    always_comb begin
        w_cand = ready & ~r_issued & ~done;
        w_free = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            w_free[f] = (r_state[f] == S_IDLE) || fu_ready[f];
        end
    end

    // Round-robin scan from rr_ptr; the n-th candidate found goes to the
    // n-th free slot (lowest-numbered first). Nothing is granted on flush.
    always_comb begin
        w_gnt_v    = '0;
        w_last     = '0;
        w_any      = 1'b0;
        w_scan     = '0;
        w_placed   = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
            w_gnt_idx[f] = '0;
        end
        for (int k = 0; k < SIZE; k++) begin
            w_scan   = r_rr + IDXW'(k);
            w_placed = 1'b0;
            if (w_cand[w_scan] && !flush_valid) begin
                for (int f = 0; f < NUM_FU; f++) begin
                    if (!w_placed && w_free[f] && !w_gnt_v[f]) begin
                        w_gnt_v[f]   = 1'b1;
                        w_gnt_idx[f] = w_scan;
                        w_placed     = 1'b1;
                        w_last       = w_scan;
                        w_any        = 1'b1;
                    end
                end
            end
        end
    end

    // One-hot of the entries granted this cycle, used to set issued_mask.
    always_comb begin
        w_gnt_mask = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (w_gnt_v[f]) begin
                w_gnt_mask[w_gnt_idx[f]] = 1'b1;
            end
        end
    end

    // Slot FSMs: flush beats everything, a new grant reloads the slot,
    // otherwise done on the held entry or an FU accept empties it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int f = 0; f < NUM_FU; f++) begin
                r_state[f] <= S_IDLE;
                r_idx[f]   <= '0;
            end
        end else if (flush_valid) begin
            for (int f = 0; f < NUM_FU; f++) begin
                r_state[f] <= S_IDLE;
            end
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (w_gnt_v[f]) begin
                    r_state[f] <= S_HOLD;
                    r_idx[f]   <= w_gnt_idx[f];
                end else if (r_state[f] == S_HOLD &&
                             (done[r_idx[f]] || fu_ready[f])) begin
                    r_state[f] <= S_IDLE;
                end
            end
        end
    end

    // Issued mask and round-robin pointer; the pointer moves to just past
    // the last entry granted and is left alone on idle or flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issued <= '0;
            r_rr     <= '0;
        end else if (flush_valid) begin
            r_issued <= '0;
        end else begin
            r_issued <= (r_issued & ~done) | w_gnt_mask;
            if (w_any) begin
                r_rr <= w_last + IDXW'(1);
            end
        end
    end

    // Slot state drives the outputs directly, so an async reset clears
    // fu_valid without waiting for a clock edge.
    always_comb begin
        fu_valid = '0;
        fu_idx   = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            fu_valid[f]              = (r_state[f] == S_HOLD);
            fu_idx[f*IDXW +: IDXW]   = r_idx[f];
        end
    end

    assign issued_mask = r_issued;
    assign rr_ptr      = r_rr;

endmodule
